// File: rtl/audio_clk_pkg.sv
// Shared types and defaults for the audio clock generation/measurement blocks.
package audio_clk_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    WAIT_FIRST,
    MEASURE,
    TIMEOUT
  } meter_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus edge register for an asynchronous single-bit input.
// Produces registered level and single-cycle rise/fall pulses.
module sync_edge_detect (
  input  logic inClock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    s1_d   = async_in;
    s2_d   = s1_q;
    prev_d = s2_q;
    rise_d = s2_q & ~prev_q;
    fall_d = ~s2_q & prev_q;
  end

  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = s2_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous clock in inClock cycles,
// with lock detection over consecutive in-tolerance periods and a stall timeout.
module clock_period_meter
  import audio_clk_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEFAULT,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOLERANCE  = 1
) (
  input  logic                 inClock,
  input  logic                 reset,
  input  logic                 measClock,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] highTime,
  output logic                 valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam int unsigned CMP_W = CNT_WIDTH + 1;
  localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic meas_level_unused;
  logic meas_rise;
  logic meas_fall;

  sync_edge_detect u_sync (
    .inClock  (inClock),
    .reset    (reset),
    .async_in (measClock),
    .level    (meas_level_unused),
    .rise     (meas_rise),
    .fall     (meas_fall)
  );

  meter_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hi_latch_q, hi_latch_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_time_q, high_time_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 timeout_q, timeout_d;

  logic [CMP_W-1:0] meas_len;
  logic [CMP_W-1:0] prev_len;
  logic [CMP_W-1:0] len_diff;
  logic             in_tol;
  logic [RUN_W-1:0] run_nxt;

  // Length of the phase ending this cycle, and its distance from the last published period.
  always_comb begin
    meas_len = CMP_W'(cnt_q) + CMP_W'(1);
    prev_len = CMP_W'(period_q);
    len_diff = (meas_len >= prev_len) ? (meas_len - prev_len) : (prev_len - meas_len);
    in_tol   = (len_diff <= CMP_W'(TOLERANCE));
    // run_q == 0 marks the first publish after WAIT_FIRST or TIMEOUT.
    if ((run_q == '0) || !in_tol) begin
      run_nxt = RUN_W'(1);
    end else if (run_q == RUN_W'(LOCK_COUNT)) begin
      run_nxt = run_q;
    end else begin
      run_nxt = run_q + RUN_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    hi_latch_d  = hi_latch_q;
    run_d       = run_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;

    case (state_q)
      WAIT_FIRST: begin
        if (meas_rise) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (meas_rise) begin
          period_d    = CNT_WIDTH'(meas_len);
          high_time_d = hi_latch_q;
          valid_d     = 1'b1;
          run_d       = run_nxt;
          locked_d    = (run_nxt == RUN_W'(LOCK_COUNT));
          cnt_d       = '0;
        end else begin
          if (meas_fall) begin
            hi_latch_d = CNT_WIDTH'(meas_len);
          end
          if (meas_len == CMP_W'(CNT_MAX)) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            run_d     = '0;
            state_d   = TIMEOUT;
          end
        end
      end
      TIMEOUT: begin
        if (meas_rise) begin
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = MEASURE;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_FIRST;
      cnt_q       <= '0;
      hi_latch_q  <= '0;
      run_q       <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_latch_q  <= hi_latch_d;
      run_q       <= run_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period   = period_q;
  assign highTime = high_time_q;
  assign valid    = valid_q;
  assign locked   = locked_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed plus randomized bench for clock_period_meter (CNT_WIDTH=8) against a
// rise/fall timeline model of the measured waveform.
module tb_clock_period_meter;

  localparam int CW      = 8;
  localparam int LOCKN   = 4;
  localparam int TOL     = 1;
  localparam int MAXV    = (1 << CW) - 1;
  // measClock edge to output visibility at the following sample point
  localparam int LAT     = 4;

  logic          inClock;
  logic          reset;
  logic          measClock;
  logic [CW-1:0] period;
  logic [CW-1:0] highTime;
  logic          valid;
  logic          locked;
  logic          timeout;

  clock_period_meter #(
    .CNT_WIDTH  (CW),
    .LOCK_COUNT (LOCKN),
    .TOLERANCE  (TOL)
  ) dut (
    .inClock   (inClock),
    .reset     (reset),
    .measClock (measClock),
    .period    (period),
    .highTime  (highTime),
    .valid     (valid),
    .locked    (locked),
    .timeout   (timeout)
  );

  initial inClock = 1'b0;
  always #5 inClock = ~inClock;

  typedef struct {
    int k;
    int per;
    int hi;
    bit lck;
  } pub_t;

  pub_t pubq[$];
  int   riseq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int iter      = 0;
  bit prev_lvl  = 1'b0;
  int last_rise = -1;
  int last_fall = -1;
  int r_eff     = -1;
  bit have_pub  = 1'b0;
  int last_per  = 0;
  int run       = 0;

  int exp_per = 0;
  int exp_hi  = 0;
  bit exp_lck = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (iter %0d)", tag, obs, exp, iter);
    end
  endtask

  task automatic model_clear();
    pubq.delete();
    riseq.delete();
    last_rise = -1;
    last_fall = -1;
    r_eff     = -1;
    have_pub  = 1'b0;
    last_per  = 0;
    run       = 0;
    exp_per   = 0;
    exp_hi    = 0;
    exp_lck   = 1'b0;
  endtask

  // A rise at drive index j publishes iff a previous rise exists within MAXV cycles.
  task automatic model_rise(input int j);
    pub_t p;
    int   g;
    int   d;
    if (last_rise >= 0 && (j - last_rise) <= MAXV) begin
      g = j - last_rise;
      d = (g > last_per) ? g - last_per : last_per - g;
      if (have_pub && d <= TOL) run = (run + 1 > LOCKN) ? LOCKN : run + 1;
      else run = 1;
      p.k   = j + LAT;
      p.per = g;
      p.hi  = last_fall - last_rise;
      p.lck = (run == LOCKN);
      pubq.push_back(p);
      have_pub = 1'b1;
      last_per = g;
    end else begin
      have_pub = 1'b0;
    end
    last_rise = j;
    riseq.push_back(j);
  endtask

  task automatic check_outputs();
    pub_t p;
    bit   exp_valid;
    bit   exp_to;
    while (riseq.size() > 0 && riseq[0] + LAT <= iter) r_eff = riseq.pop_front();
    exp_valid = 1'b0;
    if (pubq.size() > 0 && pubq[0].k == iter) begin
      p         = pubq.pop_front();
      exp_valid = 1'b1;
      exp_per   = p.per;
      exp_hi    = p.hi;
      exp_lck   = p.lck;
    end
    // stall detection fires MAXV cycles after the last rise took effect
    exp_to = (r_eff >= 0) && (iter - r_eff >= MAXV + LAT);
    if (exp_to) exp_lck = 1'b0;
    chk("valid",    32'(valid),    32'(exp_valid));
    chk("period",   32'(period),   32'(exp_per));
    chk("highTime", 32'(highTime), 32'(exp_hi));
    chk("locked",   32'(locked),   32'(exp_lck));
    chk("timeout",  32'(timeout),  32'(exp_to));
  endtask

  task automatic step(input logic lvl);
    @(negedge inClock);
    check_outputs();
    if (lvl && !prev_lvl) model_rise(iter);
    if (!lvl && prev_lvl) last_fall = iter;
    measClock = lvl;
    prev_lvl  = lvl;
    iter++;
  endtask

  task automatic phase(input int h, input int l);
    for (int i = 0; i < h; i++) step(1'b1);
    for (int i = 0; i < l; i++) step(1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_period"},   32'(period),   32'd0);
    chk({tag, "_highTime"}, 32'(highTime), 32'd0);
    chk({tag, "_valid"},    32'(valid),    32'd0);
    chk({tag, "_locked"},   32'(locked),   32'd0);
    chk({tag, "_timeout"},  32'(timeout),  32'd0);
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    #1;
    check_zero("midrst");
    model_clear();
    repeat (2) @(negedge inClock);
    reset = 1'b0;
  endtask

  initial begin
    int base;
    int per;
    int h;
    reset     = 1'b1;
    measClock = 1'b0;
    model_clear();
    repeat (3) @(negedge inClock);
    check_zero("rst");
    reset = 1'b0;

    // divide-by-4 source
    repeat (6) phase(2, 2);
    // period 10, high 3
    repeat (6) phase(3, 7);
    // periods 10, 11, 10, 10, 12
    phase(4, 6); phase(4, 7); phase(4, 6); phase(4, 6); phase(4, 8);
    // reset during a stretched low phase, then divide-by-4 again
    repeat (3) phase(2, 2);
    phase(2, 4);
    mid_reset();
    repeat (5) phase(2, 2);
    // lock, stop, timeout, restart
    repeat (5) phase(4, 4);
    repeat (300) step(1'b0);
    repeat (4) phase(5, 5);
    // period exactly at the limit, then one past it
    phase(100, 155);
    phase(3, 3);
    phase(100, 156);
    repeat (3) phase(3, 3);
    // random phases
    for (int n = 0; n < 12; n++) phase($urandom_range(2, 9), $urandom_range(2, 9));
    // jittered stable period around a random base
    base = $urandom_range(8, 40);
    for (int n = 0; n < 10; n++) begin
      per = base + $urandom_range(0, 1);
      h   = $urandom_range(2, per - 2);
      phase(h, per - h);
    end
    repeat (10) step(1'b0);
    chk("pending", 32'(pubq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
